// File: rtl/isqrt_arb_pkg.sv
// Shared constants and helpers for the isqrt round-robin arbiter slice.
package isqrt_arb_pkg;

  localparam int ISQRT_X_W = 32;
  localparam int ISQRT_Y_W = 16;

  // Width of a requester tag; never narrower than one bit.
  function automatic int tag_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/isqrt_tag_fifo.sv
// In-order FIFO of requester tags for operations in flight inside the isqrt.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module isqrt_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [TAG_W-1:0]       push_tag,
  input  logic                   pop,
  output logic [TAG_W-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; over/underflow requests are ignored.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined isqrt among N_REQ requesters.
// Results are routed back through an in-order tag FIFO.
// Optional counters: define ISQRT_RR_ARBITER_STATS_EN to add grant_cnt/stall_cnt.
module isqrt_rr_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_x_vld,
  input  logic [N_REQ*ISQRT_X_W-1:0] req_x,
  output logic [N_REQ-1:0]           req_x_rdy,
  output logic [N_REQ-1:0]           req_y_vld,
  output logic [ISQRT_Y_W-1:0]       req_y,
  output logic                       isqrt_x_vld,
  output logic [ISQRT_X_W-1:0]       isqrt_x,
  input  logic                       isqrt_y_vld,
  input  logic [ISQRT_Y_W-1:0]       isqrt_y,
  output logic                       err
`ifdef ISQRT_RR_ARBITER_STATS_EN
  ,
  output logic [N_REQ*16-1:0]        grant_cnt,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int TAG_W = tag_w(N_REQ);

  logic [TAG_W-1:0]               ptr_q, ptr_d;
  logic                           err_q, err_d;
  logic [TAG_W-1:0]               winner;
  logic                           found;
  logic                           issue;
  logic                           pop;
  logic [TAG_W-1:0]               fifo_head;
  logic [$clog2(MAX_INFLIGHT):0]  fifo_count;
  logic                           fifo_full;
  logic                           fifo_empty;

  isqrt_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (issue),
    .push_tag (winner),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Pick the first valid requester at or after the priority pointer, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!found && req_x_vld[idx]) begin
        found  = 1'b1;
        winner = TAG_W'(idx);
      end
    end
  end

  // Grant/issue on the argument side and tag-routed delivery on the result side.
  always_comb begin
    issue     = found & ~fifo_full;
    req_x_rdy = '0;
    if (issue) begin
      req_x_rdy[winner] = 1'b1;
    end
    isqrt_x_vld = issue;
    isqrt_x     = req_x[ISQRT_X_W*int'(winner) +: ISQRT_X_W];
    pop         = isqrt_y_vld & ~fifo_empty;
    req_y_vld   = '0;
    if (pop) begin
      req_y_vld[fifo_head] = 1'b1;
    end
    req_y = isqrt_y;
  end

  // Advance the pointer past the winner on issue; latch a result arriving with nothing in flight.
  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (winner == TAG_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end
    err_d = err_q | (isqrt_y_vld & (fifo_count == '0));
  end

  // Pointer and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

`ifdef ISQRT_RR_ARBITER_STATS_EN
  logic [N_REQ*16-1:0] grant_cnt_q, grant_cnt_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;

  // Saturating per-requester issue counters and a full-FIFO stall counter.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_x_rdy[i] && (grant_cnt_q[16*i +: 16] != 16'hFFFF)) begin
        grant_cnt_d[16*i +: 16] = grant_cnt_q[16*i +: 16] + 16'd1;
      end
    end
    if ((|req_x_vld) && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Self-checking bench for isqrt_rr_arbiter (N_REQ=3, MAX_INFLIGHT=4).
// The bench plays the isqrt instance and keeps a queue-based reference model.
module tb_isqrt_rr_arbiter;

  localparam int N   = 3;
  localparam int MAX = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_x_vld;
  logic [N*32-1:0] req_x;
  logic [N-1:0]    req_x_rdy;
  logic [N-1:0]    req_y_vld;
  logic [15:0]     req_y;
  logic            isqrt_x_vld;
  logic [31:0]     isqrt_x;
  logic            isqrt_y_vld;
  logic [15:0]     isqrt_y;
  logic            err;
`ifdef ISQRT_RR_ARBITER_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  isqrt_rr_arbiter #(.N_REQ(N), .MAX_INFLIGHT(MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_x_vld   (req_x_vld),
    .req_x       (req_x),
    .req_x_rdy   (req_x_rdy),
    .req_y_vld   (req_y_vld),
    .req_y       (req_y),
    .isqrt_x_vld (isqrt_x_vld),
    .isqrt_x     (isqrt_x),
    .isqrt_y_vld (isqrt_y_vld),
    .isqrt_y     (isqrt_y),
    .err         (err)
`ifdef ISQRT_RR_ARBITER_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of in-flight operations (owner + true root), priority pointer, error flag.
  typedef struct {
    int          tag;
    logic [15:0] res;
  } inflight_t;

  typedef struct {
    logic [N-1:0] exp_rdy;
    logic [N-1:0] obs_rdy;
    bit           exp_issue;
    logic         obs_xvld;
    logic [31:0]  exp_x;
    logic [31:0]  obs_x;
    bit           exp_pop;
    logic [N-1:0] exp_yvld;
    logic [N-1:0] obs_yvld;
    logic [15:0]  exp_y;
    logic [15:0]  obs_y;
    logic         exp_err;
    logic         obs_err;
  } cyc_t;

  inflight_t mq[$];
  int        mptr;
  bit        merr;
  int        n_checks;
  int        n_fail;

  function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'h1 << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return r;
  endfunction

  // One clock cycle: drive inputs after the falling edge, predict and sample, then update the model at the rising edge.
  task automatic run_cycle(input logic [N-1:0] vld, input logic [N*32-1:0] xs, input bit ret, output cyc_t c);
    int  w;
    bit  found;
    @(negedge clk);
    req_x_vld   = vld;
    req_x       = xs;
    isqrt_y_vld = ret;
    isqrt_y     = (mq.size() > 0) ? mq[0].res : 16'($urandom);
    #1;
    found = 0;
    w     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && vld[(mptr + k) % N]) begin
        found = 1;
        w     = (mptr + k) % N;
      end
    end
    c.exp_issue = found && (mq.size() < MAX);
    c.exp_rdy   = '0;
    if (c.exp_issue) c.exp_rdy[w] = 1'b1;
    c.exp_x     = xs[32*w +: 32];
    c.exp_pop   = ret && (mq.size() > 0);
    c.exp_yvld  = '0;
    if (c.exp_pop) c.exp_yvld[mq[0].tag] = 1'b1;
    c.exp_y     = (mq.size() > 0) ? mq[0].res : 16'h0;
    c.exp_err   = merr;
    c.obs_rdy   = req_x_rdy;
    c.obs_xvld  = isqrt_x_vld;
    c.obs_x     = isqrt_x;
    c.obs_yvld  = req_y_vld;
    c.obs_y     = req_y;
    c.obs_err   = err;
    @(posedge clk);
    if (ret && mq.size() == 0) merr = 1;
    if (c.exp_pop) mq.delete(0);
    if (c.exp_issue) begin
      mq.push_back('{tag: w, res: ref_sqrt(c.exp_x)});
      mptr = (w + 1) % N;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst         = 1'b1;
    req_x_vld   = '0;
    req_x       = '0;
    isqrt_y_vld = 1'b0;
    isqrt_y     = '0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    mptr = 0;
    merr = 0;
  endtask

  task automatic test_reset();
    cyc_t c;
    do_reset(2);
    run_cycle('0, '0, 1'b0, c);
    n_checks++; if (c.obs_rdy !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_rdy: got %b expected %b", c.obs_rdy, 3'b000); end
    n_checks++; if (c.obs_yvld !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_yvld: got %b expected %b", c.obs_yvld, 3'b000); end
    n_checks++; if (c.obs_xvld !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_xvld: got %b expected 0", c.obs_xvld); end
    n_checks++; if (c.obs_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", c.obs_err); end
  endtask

  task automatic test_single();
    cyc_t c;
    logic [31:0] xv [2];
    logic [15:0] yv [2];
    xv[0] = 32'd144;
    xv[1] = 32'd1000000;
    yv[0] = 16'd12;
    yv[1] = 16'd1000;
    for (int i = 0; i < 2; i++) begin
      run_cycle(3'b001, {64'd0, xv[i]}, 1'b0, c);
      n_checks++; if (c.obs_rdy !== 3'b001) begin n_fail++; $display("[TB] FAIL single_rdy%0d: got %b expected 001", i, c.obs_rdy); end
      n_checks++; if (c.obs_x !== xv[i]) begin n_fail++; $display("[TB] FAIL single_x%0d: got %0d expected %0d", i, c.obs_x, xv[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      run_cycle('0, '0, 1'b1, c);
      n_checks++; if (c.obs_yvld !== 3'b001) begin n_fail++; $display("[TB] FAIL single_yvld%0d: got %b expected 001", i, c.obs_yvld); end
      n_checks++; if (c.obs_y !== yv[i]) begin n_fail++; $display("[TB] FAIL single_y%0d: got %0d expected %0d", i, c.obs_y, yv[i]); end
    end
    run_cycle('0, '0, 1'b0, c);
    n_checks++; if (c.obs_yvld !== 3'b000) begin n_fail++; $display("[TB] FAIL single_idle_yvld: got %b expected 000", c.obs_yvld); end
  endtask

  task automatic test_alternate();
    cyc_t c;
    for (int i = 0; i < 12; i++) begin
      run_cycle(3'b011, {32'd0, 32'd81, 32'd16}, mq.size() > 0, c);
      n_checks++; if (c.obs_rdy !== c.exp_rdy) begin n_fail++; $display("[TB] FAIL alt_rdy%0d: got %b expected %b", i, c.obs_rdy, c.exp_rdy); end
      n_checks++; if (c.obs_yvld !== c.exp_yvld) begin n_fail++; $display("[TB] FAIL alt_yvld%0d: got %b expected %b", i, c.obs_yvld, c.exp_yvld); end
      if (c.exp_pop) begin
        n_checks++;
        if (c.obs_y !== (c.exp_yvld[0] ? 16'd4 : 16'd9)) begin n_fail++; $display("[TB] FAIL alt_y%0d: got %0d expected %0d", i, c.obs_y, c.exp_yvld[0] ? 4 : 9); end
      end
    end
    while (mq.size() > 0) run_cycle('0, '0, 1'b1, c);
  endtask

  task automatic test_full();
    cyc_t c;
    logic [N*32-1:0] xs;
    xs = {64'd0, 32'($urandom)};
    for (int i = 0; i < 6; i++) begin
      run_cycle(3'b001, xs, 1'b0, c);
      n_checks++; if (c.obs_rdy !== ((i < MAX) ? 3'b001 : 3'b000)) begin n_fail++; $display("[TB] FAIL full_fill_rdy%0d: got %b", i, c.obs_rdy); end
      n_checks++; if (c.obs_xvld !== c.exp_issue) begin n_fail++; $display("[TB] FAIL full_fill_xvld%0d: got %b expected %b", i, c.obs_xvld, c.exp_issue); end
    end
    run_cycle(3'b001, xs, 1'b1, c);
    n_checks++; if (c.obs_rdy !== 3'b000) begin n_fail++; $display("[TB] FAIL full_pop_rdy: got %b expected 000", c.obs_rdy); end
    n_checks++; if (c.obs_yvld !== 3'b001) begin n_fail++; $display("[TB] FAIL full_pop_yvld: got %b expected 001", c.obs_yvld); end
    run_cycle(3'b001, xs, 1'b0, c);
    n_checks++; if (c.obs_rdy !== 3'b001) begin n_fail++; $display("[TB] FAIL full_refill_rdy: got %b expected 001", c.obs_rdy); end
    run_cycle(3'b001, xs, 1'b0, c);
    n_checks++; if (c.obs_rdy !== 3'b000) begin n_fail++; $display("[TB] FAIL full_again_rdy: got %b expected 000", c.obs_rdy); end
    for (int i = 0; i < MAX; i++) begin
      run_cycle('0, '0, 1'b1, c);
      n_checks++; if (c.obs_yvld !== c.exp_yvld) begin n_fail++; $display("[TB] FAIL full_drain_yvld%0d: got %b expected %b", i, c.obs_yvld, c.exp_yvld); end
      n_checks++; if (c.obs_y !== c.exp_y) begin n_fail++; $display("[TB] FAIL full_drain_y%0d: got %0d expected %0d", i, c.obs_y, c.exp_y); end
    end
  endtask

  task automatic test_err();
    cyc_t c;
    run_cycle('0, '0, 1'b1, c);
    n_checks++; if (c.obs_yvld !== 3'b000) begin n_fail++; $display("[TB] FAIL err_yvld: got %b expected 000", c.obs_yvld); end
    for (int i = 0; i < 4; i++) begin
      run_cycle('0, '0, 1'b0, c);
      n_checks++; if (c.obs_err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky%0d: got %b expected 1", i, c.obs_err); end
    end
    do_reset(1);
    run_cycle(3'b100, {32'd625, 64'd0}, 1'b0, c);
    n_checks++; if (c.obs_err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_cleared: got %b expected 0", c.obs_err); end
    n_checks++; if (c.obs_rdy !== 3'b100) begin n_fail++; $display("[TB] FAIL err_after_rst_rdy: got %b expected 100", c.obs_rdy); end
    run_cycle('0, '0, 1'b1, c);
    n_checks++; if (c.obs_y !== 16'd25 || c.obs_yvld !== 3'b100) begin n_fail++; $display("[TB] FAIL err_after_rst_y: got %0d/%b expected 25/100", c.obs_y, c.obs_yvld); end
  endtask

  task automatic test_reset_inflight();
    cyc_t c;
    for (int i = 0; i < 3; i++) run_cycle(3'b111, {32'($urandom), 32'($urandom), 32'($urandom)}, 1'b0, c);
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      run_cycle('0, '0, 1'b0, c);
      n_checks++; if (c.obs_yvld !== 3'b000) begin n_fail++; $display("[TB] FAIL rstfl_yvld%0d: got %b expected 000", i, c.obs_yvld); end
    end
    run_cycle(3'b010, {32'd0, 32'd49, 32'd0}, 1'b0, c);
    n_checks++; if (c.obs_rdy !== 3'b010) begin n_fail++; $display("[TB] FAIL rstfl_rdy: got %b expected 010", c.obs_rdy); end
    n_checks++; if (c.obs_x !== 32'd49) begin n_fail++; $display("[TB] FAIL rstfl_x: got %0d expected 49", c.obs_x); end
    run_cycle('0, '0, 1'b1, c);
    n_checks++; if (c.obs_yvld !== 3'b010) begin n_fail++; $display("[TB] FAIL rstfl_yvld: got %b expected 010", c.obs_yvld); end
    n_checks++; if (c.obs_y !== 16'd7) begin n_fail++; $display("[TB] FAIL rstfl_y: got %0d expected 7", c.obs_y); end
  endtask

  task automatic test_random();
    cyc_t c;
    logic [N-1:0] vld;
    bit           ret;
    for (int i = 0; i < 400; i++) begin
      vld = ((i / 50) % 2 == 1) ? 3'b111 : N'($urandom);
      ret = (mq.size() > 0) && ($urandom_range(2, 0) != 0);
      run_cycle(vld, {32'($urandom), 32'($urandom), 32'($urandom)}, ret, c);
      n_checks++; if (c.obs_rdy !== c.exp_rdy) begin n_fail++; $display("[TB] FAIL rnd_rdy%0d: got %b expected %b", i, c.obs_rdy, c.exp_rdy); end
      n_checks++; if (c.obs_xvld !== c.exp_issue) begin n_fail++; $display("[TB] FAIL rnd_xvld%0d: got %b expected %b", i, c.obs_xvld, c.exp_issue); end
      if (c.exp_issue) begin
        n_checks++; if (c.obs_x !== c.exp_x) begin n_fail++; $display("[TB] FAIL rnd_x%0d: got %h expected %h", i, c.obs_x, c.exp_x); end
      end
      n_checks++; if (c.obs_yvld !== c.exp_yvld) begin n_fail++; $display("[TB] FAIL rnd_yvld%0d: got %b expected %b", i, c.obs_yvld, c.exp_yvld); end
      if (c.exp_pop) begin
        n_checks++; if (c.obs_y !== c.exp_y) begin n_fail++; $display("[TB] FAIL rnd_y%0d: got %0d expected %0d", i, c.obs_y, c.exp_y); end
      end
      n_checks++; if (c.obs_err !== c.exp_err) begin n_fail++; $display("[TB] FAIL rnd_err%0d: got %b expected %b", i, c.obs_err, c.exp_err); end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    mptr        = 0;
    merr        = 0;
    rst         = 1'b1;
    req_x_vld   = '0;
    req_x       = '0;
    isqrt_y_vld = 1'b0;
    isqrt_y     = '0;
    $display("[TB] starting isqrt_rr_arbiter bench");
    test_reset();
    test_single();
    test_alternate();
    test_full();
    test_err();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
